// File: rtl/arith_result_accumulator.sv
// Batch accumulator for adder/multiplier results: sums BATCH transfers with saturation,
// then holds the total in DONE until the downstream handshake.
module arith_result_accumulator #(
  parameter int unsigned BATCH = 8,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic [5:0]       in_result,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_count,
  output logic             sat,
  output logic             mode_err
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [ACC_W-1:0] AccMax   = {ACC_W{1'b1}};
  localparam logic [3:0]       BatchCnt = 4'(BATCH);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             bad_mode;
  logic [ACC_W-1:0] value;
  logic [ACC_W:0]   sum;
  logic [3:0]       count_inc;

  // in_ready depends only on the state register, so xfer never loops back into in_ready.
  assign in_ready  = (state_q != StDone);
  assign out_valid = (state_q == StDone);
  assign xfer      = in_valid & in_ready;

  always_comb begin
    value = '0;
    if (in_mode) begin
      value[3:0] = in_result[3:0];
    end else begin
      value[5:0] = in_result;
    end
  end

  assign bad_mode  = in_mode & (|in_result[5:4]);
  assign sum       = {1'b0, acc_q} + {1'b0, value};
  assign count_inc = count_q + 4'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    err_d   = err_q;
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            state_d = StAccum;
            acc_d   = value;
            count_d = 4'd1;
            sat_d   = 1'b0;
            err_d   = bad_mode;
          end
        end
        StAccum: begin
          if (xfer) begin
            acc_d   = sum[ACC_W] ? AccMax : sum[ACC_W-1:0];
            sat_d   = sat_q | sum[ACC_W];
            err_d   = err_q | bad_mode;
            count_d = count_inc;
            if (count_inc == BatchCnt) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
            err_d   = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign sat       = sat_q;
  assign mode_err  = err_q;

endmodule

// File: doc/arith_result_accumulator.md
ARITH_RESULT_ACCUMULATOR -- requirements
Module: arith_result_accumulator

Interface
REQ-001 Parameter BATCH, default 8, number of results accepted per batch (legal 2..15).
REQ-002 Parameter ACC_W, default 8, accumulator width in bits (legal 7..12).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clear  input  1  synchronous abort; discards the current batch.
REQ-006 in_valid  input  1  upstream arithmetic result present.
REQ-007 in_mode  input  1  1 = adder result, 0 = multiplier result.
REQ-008 in_result  input  6  result from the adder/multiplier stage; adder results use bits [3:0].
REQ-009 in_ready  output  1  block can accept in_result this cycle.
REQ-010 out_valid  output  1  batch total is available.
REQ-011 out_ready  input  1  downstream accepts the batch total.
REQ-012 out_sum  output  ACC_W  saturated batch total.
REQ-013 out_count  output  4  number of results accepted in the current batch.
REQ-014 sat  output  1  total clipped at 2^ACC_W-1 during this batch.
REQ-015 mode_err  output  1  an adder-mode result with in_result[5:4] != 0 was received in this batch.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-017 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE. It is a registered state decode with no combinational path from in_valid.
REQ-019 On a transfer in IDLE, the block SHALL:
  - load the accumulator with the value;
  - set out_count to 1;
  - move to ACCUM.
REQ-020 On a transfer in ACCUM, the block SHALL add the value to the accumulator and increment out_count.
REQ-021 The transfer value SHALL be in_result zero-extended to ACC_W when in_mode=0, and {2'b00, in_result[3:0]} when in_mode=1.
REQ-022 If in_mode=1 and in_result[5:4] != 0 on a transfer, mode_err SHALL set. It is sticky until the batch ends.
REQ-023 Addition SHALL saturate: if acc+value > 2^ACC_W-1, the accumulator SHALL become 2^ACC_W-1 and sat SHALL set (sticky).
REQ-024 On the transfer that brings out_count to BATCH, the FSM SHALL enter DONE on the next edge, with out_valid=1 in that cycle (one-cycle latency after the last transfer).
REQ-025 In DONE, out_sum, out_count, sat and mode_err SHALL hold stable until out_ready=1.
REQ-026 On out_valid=1 and out_ready=1, the block SHALL:
  - return to IDLE on the next edge;
  - clear the accumulator, out_count, sat and mode_err to 0;
  - drop out_valid.
REQ-027 The first new input transfer SHALL be possible in the cycle after the output handshake. There is no transfer in the handshake cycle itself.
REQ-028 out_valid SHALL be 1 only in DONE. out_sum SHALL show the live accumulator in all states.
REQ-029 clear=1 SHALL override all other inputs in any state:
  - next state IDLE;
  - accumulator, out_count, sat and mode_err set to 0;
  - out_valid set to 0;
  - any transfer in that cycle discarded.
REQ-030 With out_ready=1 held permanently, a batch SHALL be delivered every BATCH+1 cycles under continuous in_valid.
REQ-031 Inputs in_mode and in_result SHALL be sampled only on transfer cycles; their values at other times have no effect.

Reset
REQ-032 rst_n=0 SHALL asynchronously force the following, independent of clk:
  - state IDLE, so in_ready=1;
  - out_valid=0;
  - out_sum=0;
  - out_count=0;
  - sat=0;
  - mode_err=0.
REQ-033 Reset asserted mid-batch or in DONE SHALL discard the partial or held total.
REQ-034 After rst_n deasserts, the block SHALL accept a transfer on the first clock edge.

Verification
REQ-035 BATCH=8, ACC_W=8: eight mul transfers of 6 (2x3) back-to-back with out_ready=1 -> out_valid=1 one cycle after the 8th transfer, with out_sum=48, out_count=8, sat=0, mode_err=0; IDLE on the next cycle.
REQ-036 Saturation: eight mul transfers of 49 (7x7) -> the total passes 255 on the 6th transfer; out_sum=255, sat=1 at DONE.
REQ-037 Mode error: add transfer with in_result=6'b010011 -> value 3 is accumulated and mode_err=1 at DONE; mode_err=0 after the output handshake.
REQ-038 Backpressure: batch completes with out_ready=0 for 5 cycles -> in_ready=0, and out_sum and out_count stay stable while in_valid pulses are ignored; the handshake occurs when out_ready rises.
REQ-039 clear after 3 transfers (values 1, 2, 4), the same cycle as a 4th in_valid -> next cycle IDLE with out_sum=0 and out_count=0; the 4th value is not counted.
REQ-040 rst_n pulsed low between clock edges in DONE -> out_valid falls immediately; all outputs are 0 before the next edge.
